// File: rtl/dap_pkg.sv
// Shared definitions for the double-accumulator processor output path:
// bus widths, processor state codes and the output-port FSM encoding.
package dap_pkg;

  localparam int DATA_W  = 16;
  localparam int STATE_W = 5;

  localparam logic [STATE_W-1:0] OUT_STATE  = 5'd20;
  localparam logic [STATE_W-1:0] HALT_STATE = 5'd31;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    FSM_RUN   = 2'd0,
    FSM_DRAIN = 2'd1,
    FSM_DONE  = 2'd2
  } fsm_e;

  // Saturating increment; the capture counter must never wrap back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word and extra-MSB pointers.
// The head register is loaded with the word that will be at the front after this edge.
module sync_fifo #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_level,
  output logic [DATA_W-1:0] o_head
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_head;

  logic              w_full;
  logic              w_empty;
  logic              w_do_push;
  logic              w_do_pop;
  logic [AW:0]       w_rd_next;
  logic [AW-1:0]     w_wr_idx;
  logic [AW-1:0]     w_rd_next_idx;
  logic [DATA_W-1:0] w_head_next;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  assign w_rd_next     = r_rd_ptr + {{AW{1'b0}}, w_do_pop};
  assign w_wr_idx      = r_wr_ptr[AW-1:0];
  assign w_rd_next_idx = w_rd_next[AW-1:0];

  // Write slot equal to the next read slot only happens when the FIFO is
  // (or becomes) empty, so the incoming word goes straight to the head.
  assign w_head_next = (w_do_push && (w_wr_idx == w_rd_next_idx)) ? i_wdata
                                                                  : r_mem[w_rd_next_idx];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[w_wr_idx] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= w_rd_next;
      r_head   <= w_head_next;
    end
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_head  = r_head;

endmodule

// File: rtl/acc_output_port.sv
// Captures the processor accumulator once per entry into the OUT state and
// streams the captured words out; reports drop overflow and halt/drain completion.
module acc_output_port
  import dap_pkg::*;
#(
  parameter  int                 DATA_W     = dap_pkg::DATA_W,
  parameter  int                 STATE_W    = dap_pkg::STATE_W,
  parameter  logic [STATE_W-1:0] OUT_STATE  = dap_pkg::OUT_STATE,
  parameter  logic [STATE_W-1:0] HALT_STATE = dap_pkg::HALT_STATE,
  parameter  int                 DEPTH      = 4,
  localparam int                 LW         = $clog2(DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [STATE_W-1:0] State,
  input  logic [DATA_W-1:0]  ACC,
  output logic [DATA_W-1:0]  OUT_Data,
  output logic               OUT_Valid,
  input  logic               OUT_Ready,
  output logic [LW-1:0]      Level,
  output logic [CNT_W-1:0]   Count,
  output logic               Overflow,
  output logic               Halted,
  output logic [1:0]         o_dbg_fsm
);

  // Handshake: a word transfers on every rising edge where OUT_Valid and
  // OUT_Ready are both high; while OUT_Valid is high and OUT_Ready low,
  // OUT_Data holds its value, and OUT_Valid never drops without a transfer.

  logic             r_hit_q;
  fsm_e             r_fsm;
  fsm_e             w_fsm_next;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_halted;

  logic             w_at_out;
  logic             w_at_halt;
  logic             w_hit;
  logic             w_run;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [LW-1:0]    w_level;
  logic [DATA_W-1:0] w_head;

  assign w_at_out  = (State == OUT_STATE);
  assign w_at_halt = (State == HALT_STATE);
  assign w_hit     = w_at_out & ~r_hit_q;
  assign w_run     = (r_fsm == FSM_RUN);

  assign w_pop  = ~w_empty & OUT_Ready;
  assign w_push = w_hit & w_run & (~w_full | w_pop);
  assign w_drop = w_hit & w_run & w_full & ~w_pop;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_push  (w_push),
    .i_wdata (ACC),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level),
    .o_head  (w_head)
  );

  // Halt with nothing queued finishes immediately; otherwise drain first.
  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      FSM_RUN: begin
        if (w_at_halt) begin
          w_fsm_next = (w_empty && !w_push) ? FSM_DONE : FSM_DRAIN;
        end
      end
      FSM_DRAIN: begin
        if (w_empty) begin
          w_fsm_next = FSM_DONE;
        end
      end
      FSM_DONE: w_fsm_next = FSM_DONE;
      default:  w_fsm_next = FSM_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_hit_q    <= 1'b0;
      r_fsm      <= FSM_RUN;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_hit_q  <= w_at_out;
      r_fsm    <= w_fsm_next;
      r_halted <= (w_fsm_next == FSM_DONE);
      if (w_push) begin
        r_count <= sat_inc(r_count);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign OUT_Data  = w_head;
  assign OUT_Valid = ~w_empty;
  assign Level     = w_level;
  assign Count     = r_count;
  assign Overflow  = r_overflow;
  assign Halted    = r_halted;
  assign o_dbg_fsm = r_fsm;

endmodule

// File: tb/tb_acc_output_port.sv
// Directed and randomized bench for acc_output_port against a queue-based
// model of capture, drop, drain and halt behaviour.
module tb_acc_output_port;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [4:0]  State = 5'd0;
  logic [15:0] ACC = 16'd0;
  logic        OUT_Ready = 1'b0;
  logic [15:0] OUT_Data;
  logic        OUT_Valid;
  logic [2:0]  Level;
  logic [15:0] Count;
  logic        Overflow;
  logic        Halted;
  logic [1:0]  o_dbg_fsm;

  acc_output_port dut (
    .CLK       (CLK),
    .RST       (RST),
    .State     (State),
    .ACC       (ACC),
    .OUT_Data  (OUT_Data),
    .OUT_Valid (OUT_Valid),
    .OUT_Ready (OUT_Ready),
    .Level     (Level),
    .Count     (Count),
    .Overflow  (Overflow),
    .Halted    (Halted),
    .o_dbg_fsm (o_dbg_fsm)
  );

  always #5 CLK = ~CLK;

  // Reference model: words waiting, capture count, sticky drop flag,
  // whether the processor was in OUT last cycle, and halt progress
  // (0 = running, 1 = halt seen and draining, 2 = finished).
  logic [15:0] m_q[$];
  int          m_count;
  bit          m_ovf;
  bit          m_prev_out;
  int          m_mode;
  bit          m_halted;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},    {31'd0, OUT_Valid}, {31'd0, (m_q.size() != 0)});
    check({tag, ".level"},    {29'd0, Level},     m_q.size());
    check({tag, ".count"},    {16'd0, Count},     m_count);
    check({tag, ".overflow"}, {31'd0, Overflow},  {31'd0, m_ovf});
    check({tag, ".halted"},   {31'd0, Halted},    {31'd0, m_halted});
    if (m_q.size() != 0) begin
      check({tag, ".data"}, {16'd0, OUT_Data}, {16'd0, m_q[0]});
    end
  endtask

  task automatic model_clock(input logic [4:0] st, input logic [15:0] acc, input logic rdy);
    int  pre_size;
    bit  hit;
    pre_size = m_q.size();
    hit = (st == 5'd20) && !m_prev_out;
    if (pre_size > 0 && rdy) void'(m_q.pop_front());
    if (hit && m_mode == 0) begin
      if (m_q.size() < 4) begin
        m_q.push_back(acc);
        if (m_count < 65535) m_count++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (m_mode == 0 && st == 5'd31) m_mode = (pre_size == 0) ? 2 : 1;
    else if (m_mode == 1 && pre_size == 0) m_mode = 2;
    m_halted   = (m_mode == 2);
    m_prev_out = (st == 5'd20);
  endtask

  task automatic step(input logic [4:0] st, input logic [15:0] acc, input logic rdy, input string tag);
    State     = st;
    ACC       = acc;
    OUT_Ready = rdy;
    @(posedge CLK);
    model_clock(st, acc, rdy);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input int n, input logic [4:0] st);
    RST       = 1'b0;
    State     = st;
    OUT_Ready = 1'b0;
    repeat (n) @(posedge CLK);
    m_q.delete();
    m_count    = 0;
    m_ovf      = 1'b0;
    m_prev_out = 1'b0;
    m_mode     = 0;
    m_halted   = 1'b0;
    #1;
    check_all("reset");
    check("reset.data0", {16'd0, OUT_Data}, 32'd0);
    RST = 1'b1;
  endtask

  initial begin
    logic [4:0] st;
    int         r;
    int         o;
    int         thr;

    // Reset held with the processor sitting in OUT; first cycle out of reset captures.
    do_reset(4, 5'd20);
    step(5'd20, 16'd77, 1'b0, "first_capture");
    step(5'd20, 16'd78, 1'b1, "first_dwell_pop");
    step(5'd0,  16'd0,  1'b1, "first_idle");

    // Single capture with a 3-cycle dwell.
    for (int i = 0; i < 3; i++) step(5'd20, 16'd5040, 1'b1, "single_dwell");
    step(5'd0, 16'd0, 1'b1, "single_idle");
    step(5'd0, 16'd0, 1'b1, "single_idle2");

    // Back-pressure: fill four entries, then a dropped fifth.
    do_reset(1, 5'd0);
    for (int i = 1; i <= 4; i++) begin
      step(5'd20, 16'(i), 1'b0, "bp_fill");
      step(5'd0,  16'd0,  1'b0, "bp_gap");
    end
    step(5'd20, 16'd5, 1'b0, "bp_drop");
    step(5'd0,  16'd0, 1'b0, "bp_hold");
    for (int i = 0; i < 5; i++) step(5'd0, 16'd0, 1'b1, "bp_drain");

    // Full FIFO with simultaneous pop and push.
    do_reset(1, 5'd0);
    for (int i = 1; i <= 4; i++) begin
      step(5'd20, 16'(i + 10), 1'b0, "fp_fill");
      step(5'd0,  16'd0,       1'b0, "fp_gap");
    end
    step(5'd20, 16'd9, 1'b1, "fp_pushpop");
    for (int i = 0; i < 5; i++) step(5'd0, 16'd0, 1'b1, "fp_drain");

    // Halt with two words queued, a post-halt hit, then the drain.
    do_reset(1, 5'd0);
    step(5'd20, 16'd11, 1'b0, "halt_fill");
    step(5'd0,  16'd0,  1'b0, "halt_gap");
    step(5'd20, 16'd22, 1'b0, "halt_fill");
    step(5'd0,  16'd0,  1'b0, "halt_gap");
    for (int i = 0; i < 3; i++) step(5'd31, 16'd0, 1'b0, "halt_hold");
    step(5'd20, 16'd33, 1'b0, "halt_ignored_hit");
    step(5'd0,  16'd0,  1'b0, "halt_gap2");
    for (int i = 0; i < 4; i++) step(5'd0, 16'd0, 1'b1, "halt_drain");

    // Halt with an empty FIFO finishes directly.
    do_reset(1, 5'd0);
    step(5'd31, 16'd0, 1'b0, "halt_empty");
    step(5'd31, 16'd0, 1'b1, "halt_empty2");

    // Mid-operation reset with Level 3 and Overflow set.
    do_reset(1, 5'd0);
    for (int i = 1; i <= 5; i++) begin
      step(5'd20, 16'(i + 100), 1'b0, "mid_fill");
      step(5'd0,  16'd0,        1'b0, "mid_gap");
    end
    step(5'd0, 16'd0, 1'b1, "mid_pop");
    step(5'd0, 16'd0, 1'b0, "mid_hold");
    do_reset(1, 5'd0);
    step(5'd0, 16'd0, 1'b1, "mid_after");

    // Randomized episodes with varying consumer throughput.
    for (int ep = 0; ep < 4; ep++) begin
      do_reset($urandom_range(1, 3), 5'd0);
      thr = ep + 1;
      for (int c = 0; c < 300; c++) begin
        r = $urandom_range(0, 15);
        if (r < 5) st = 5'd20;
        else if (r == 15 && c > 150) st = 5'd31;
        else begin
          o = $urandom_range(0, 29);
          if (o >= 20) o = o + 1;
          st = 5'(o);
        end
        step(st, 16'($urandom), ($urandom_range(0, 4) < thr), "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
